// File: rtl/timer_arbiter.sv
// timer_arbiter
// Shares one counter timer among N_REQ requesters. A requester is picked
// round-robin, its threshold is latched into the timer, and the timer is cleared
// for one cycle. The timer then runs on the prescaler tick until it reports
// finished, and the owner gets a one-cycle done pulse.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   tick            prescaler strobe; gates the timer enable while running
//   req[N_REQ]      per-requester delay request, held until done or withdrawn
//   delay           packed per-requester thresholds, slice i = [(i+1)*WIDTH-1 : i*WIDTH]
//   gnt[N_REQ]      one-hot owner of the timer, zero when idle
//   done[N_REQ]     one-cycle completion pulse to the owner
//   busy            timer allocated
//   tmr_en          timer enable
//   tmr_reset       timer clear
//   tmr_threshold   registered threshold for the timer
//   tmr_finished    finished flag from the timer
module timer_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] delay,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   tmr_en,
    output logic                   tmr_reset,
    output logic [WIDTH-1:0]       tmr_threshold,
    input  logic                   tmr_finished
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             pick_valid;
    logic [WIDTH-1:0] delay_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign delay_arr[gi] = delay[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin search starting just after the last finished owner. The loop
    // walks from the farthest candidate to the nearest so the nearest set
    // request is the last one written and therefore wins.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        cand       = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(ptr) + k) % N_REQ);
            if (req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Owner and threshold are captured only at grant time, so later changes on
    // delay do not disturb a running job. The pointer moves only on a completed
    // job; an aborted job leaves the priority order untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner         <= '0;
            ptr           <= IDX_W'(N_REQ - 1);
            tmr_threshold <= '0;
        end else begin
            if (state == IDLE && pick_valid) begin
                owner         <= pick;
                tmr_threshold <= delay_arr[pick];
            end
            if (state == DONE) begin
                ptr <= owner;
            end
        end
    end

    always_comb begin
        state_next = state;
        gnt        = '0;
        done       = '0;
        busy       = 1'b0;
        tmr_en     = 1'b0;
        tmr_reset  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                busy       = 1'b1;
                gnt[owner] = 1'b1;
                tmr_en     = 1'b1;
                tmr_reset  = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                busy       = 1'b1;
                gnt[owner] = 1'b1;
                tmr_en     = tick;
                // A withdrawn request beats a simultaneous finish.
                if (!req[owner]) begin
                    state_next = IDLE;
                end else if (tmr_finished) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                gnt[owner]  = 1'b1;
                done[owner] = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Keep the shared timer cleared for as long as reset is held.
        if (reset) begin
            tmr_en    = 1'b1;
            tmr_reset = 1'b1;
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter
// Self-checking bench for timer_arbiter. Contains a behavioural model of the
// shared counter timer feeding tmr_finished, and a job-level reference model of
// the arbiter that predicts the outputs every cycle. Directed sequences check
// absolute latencies and grant order; a randomized phase covers the rest.
module tb_timer_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 10;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   tick = 1'b0;
    logic [N_REQ-1:0]       req = '0;
    logic [N_REQ*WIDTH-1:0] delay = '0;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic                   tmrEn;
    logic                   tmrReset;
    logic [WIDTH-1:0]       tmrThreshold;
    logic                   tmrFinished;

    always #5 clk = ~clk;

    timer_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .req          (req),
        .delay        (delay),
        .gnt          (gnt),
        .done         (done),
        .busy         (busy),
        .tmr_en       (tmrEn),
        .tmr_reset    (tmrReset),
        .tmr_threshold(tmrThreshold),
        .tmr_finished (tmrFinished)
    );

    // Shared timer: counts enabled cycles up to threshold and then holds finished.
    logic [WIDTH-1:0] tmrCtr = '0;
    logic             tmrFin = 1'b0;

    always @(posedge clk) begin
        if (tmrEn) begin
            if (tmrReset) begin
                tmrCtr <= '0;
                tmrFin <= 1'b0;
            end else if (tmrCtr == tmrThreshold) begin
                tmrFin <= 1'b1;
            end else begin
                tmrCtr <= tmrCtr + 1'b1;
            end
        end
    end

    assign tmrFinished = tmrFin;

    int checks = 0;
    int errors = 0;

    // Job-level reference: a job is either absent or in its clear, run or
    // completion cycle; mTicks counts enabled run cycles since the clear.
    bit modelValid = 1'b0;
    bit mActive = 1'b0;
    int mPhase = 0;
    int mOwner = 0;
    int mThr = 0;
    int mPtr = N_REQ - 1;
    int mTicks = 0;

    int cycleNo = 0;
    int grantCycles[$];
    int grantOwners[$];
    int doneCycles[$];

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d, t=%0t)",
                     tag, observed, expected, cycleNo, $time);
        end
    endtask

    function automatic int onehotIndex(input logic [N_REQ-1:0] v);
        int r = -1;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    task automatic compareModel();
        logic [N_REQ-1:0] expGnt;
        logic [N_REQ-1:0] expDone;
        logic             expEn;
        logic             expRst;
        expGnt  = mActive ? N_REQ'(1) << mOwner : '0;
        expDone = (mActive && mPhase == 2) ? N_REQ'(1) << mOwner : '0;
        expRst  = reset || (mActive && mPhase == 0);
        expEn   = expRst || (mActive && mPhase == 1 && tick);
        checkOutput("gnt", gnt, expGnt);
        checkOutput("done", done, expDone);
        checkOutput("busy", busy, mActive);
        checkOutput("tmr_en", tmrEn, expEn);
        checkOutput("tmr_reset", tmrReset, expRst);
        checkOutput("tmr_threshold", tmrThreshold, mThr);
        checkOutput("gnt_onehot0", $onehot0(gnt), 1);
        checkOutput("done_in_gnt", done & ~gnt, 0);
    endtask

    task automatic updateModel();
        bit found;
        int idx;
        if (reset) begin
            mActive    = 1'b0;
            mThr       = 0;
            mPtr       = N_REQ - 1;
            modelValid = 1'b1;
        end else if (modelValid) begin
            if (!mActive) begin
                found = 1'b0;
                for (int k = 1; k <= N_REQ; k++) begin
                    idx = (mPtr + k) % N_REQ;
                    if (!found && req[idx]) begin
                        found  = 1'b1;
                        mOwner = idx;
                    end
                end
                if (found) begin
                    mThr    = int'(delay[mOwner*WIDTH +: WIDTH]);
                    mActive = 1'b1;
                    mPhase  = 0;
                end
            end else begin
                case (mPhase)
                    0: begin
                        mPhase = 1;
                        mTicks = 0;
                    end
                    1: begin
                        if (!req[mOwner]) begin
                            mActive = 1'b0;
                        end else if (mTicks == mThr + 1) begin
                            mPhase = 2;
                        end else if (tick) begin
                            mTicks++;
                        end
                    end
                    default: begin
                        mActive = 1'b0;
                        mPtr    = mOwner;
                    end
                endcase
            end
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, compare shortly after,
    // then advance the reference on the rising edge.
    task automatic applyStimulus(input logic r, input logic [N_REQ-1:0] rq,
                                 input logic tk, input logic [N_REQ*WIDTH-1:0] dl);
        @(negedge clk);
        reset = r;
        req   = rq;
        tick  = tk;
        delay = dl;
        #1;
        if (modelValid) compareModel();
        if (!reset && tmrReset) begin
            grantCycles.push_back(cycleNo);
            grantOwners.push_back(onehotIndex(gnt));
        end
        if (done != '0) doneCycles.push_back(cycleNo);
        @(posedge clk);
        updateModel();
        cycleNo++;
    endtask

    task automatic startSection();
        applyStimulus(1'b1, '0, 1'b0, '0);
        applyStimulus(1'b1, '0, 1'b0, '0);
        cycleNo = 0;
        grantCycles.delete();
        grantOwners.delete();
        doneCycles.delete();
    endtask

    function automatic logic [N_REQ*WIDTH-1:0] setSlice(
        input logic [N_REQ*WIDTH-1:0] v, input int i, input int val);
        logic [N_REQ*WIDTH-1:0] r = v;
        r[i*WIDTH +: WIDTH] = WIDTH'(val);
        return r;
    endfunction

    initial begin
        logic [N_REQ*WIDTH-1:0] dl;
        logic [N_REQ-1:0]       rq;
        int                     expOrder[5] = '{0, 1, 2, 3, 0};

        // Single requester, threshold 5: clear at 1, done at 9.
        startSection();
        dl = setSlice('0, 0, 5);
        for (int c = 0; c < 11; c++) applyStimulus(1'b0, 4'b0001, 1'b1, dl);
        for (int c = 0; c < 4; c++) applyStimulus(1'b0, 4'b0000, 1'b1, dl);
        checkOutput("t1_grant_count_min", grantCycles.size() >= 1, 1);
        if (grantCycles.size() >= 1) checkOutput("t1_clear_cycle", grantCycles[0], 1);
        checkOutput("t1_done_count", doneCycles.size(), 1);
        if (doneCycles.size() >= 1) checkOutput("t1_done_cycle", doneCycles[0], 9);

        // All requesting with zero thresholds: strict rotation 0,1,2,3,0.
        startSection();
        for (int c = 0; c < 22; c++) applyStimulus(1'b0, 4'b1111, 1'b1, '0);
        checkOutput("t2_grant_count", grantOwners.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < grantOwners.size()) checkOutput("t2_grant_order", grantOwners[i], expOrder[i]);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < doneCycles.size() && i < grantCycles.size())
                checkOutput("t2_done_latency", doneCycles[i] - grantCycles[i], 3);
        end

        // Reset in the middle of a run: no done, then req[0] wins over req[3].
        startSection();
        dl = setSlice('0, 3, 20);
        for (int c = 0; c < 6; c++) applyStimulus(1'b0, 4'b1000, 1'b1, dl);
        applyStimulus(1'b1, 4'b1001, 1'b1, dl);
        checkOutput("t5_no_done", doneCycles.size(), 0);
        grantOwners.delete();
        for (int c = 0; c < 4; c++) applyStimulus(1'b0, 4'b1001, 1'b1, dl);
        checkOutput("t5_regrant_count", grantOwners.size(), 1);
        if (grantOwners.size() >= 1) checkOutput("t5_first_owner", grantOwners[0], 0);

        // Threshold changes after the grant are ignored: 7 is kept, done at 11.
        startSection();
        dl = setSlice('0, 1, 7);
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, 4'b0010, 1'b1, dl);
        dl = setSlice('0, 1, 1);
        for (int c = 3; c < 13; c++) applyStimulus(1'b0, 4'b0010, 1'b1, dl);
        checkOutput("t6_done_count_min", doneCycles.size() >= 1, 1);
        if (doneCycles.size() >= 1) checkOutput("t6_done_cycle", doneCycles[0], 11);

        // Largest threshold: no wrap, done at 1023 + 4.
        startSection();
        dl = setSlice('0, 0, (1 << WIDTH) - 1);
        for (int c = 0; c < 1029; c++) applyStimulus(1'b0, 4'b0001, 1'b1, dl);
        checkOutput("tmax_done_count_min", doneCycles.size() >= 1, 1);
        if (doneCycles.size() >= 1) checkOutput("tmax_done_cycle", doneCycles[0], 1027);

        // Randomized traffic: requests come and go, ticks are sparse, delays
        // change at any time, and occasional resets land outside completion.
        startSection();
        dl = '0;
        rq = '0;
        for (int c = 0; c < 5000; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (rq[i]) begin
                    if ($urandom_range(0, 39) == 0) rq[i] = 1'b0;
                end else begin
                    if ($urandom_range(0, 5) == 0) rq[i] = 1'b1;
                end
            end
            if ($urandom_range(0, 7) == 0)
                dl = setSlice(dl, $urandom_range(0, N_REQ - 1), $urandom_range(0, 6));
            applyStimulus((($urandom_range(0, 299) == 0) && !(mActive && mPhase == 2)),
                          rq, ($urandom_range(0, 3) != 0), dl);
        end
        checkOutput("rand_had_grants", grantCycles.size() > 20, 1);
        checkOutput("rand_had_dones", doneCycles.size() > 20, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
